hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Stall/flush controller for the 5-stage pipeline. It handles the dependencies that the forwarding muxes cannot cover.
- Detects load-use hazards and ID-stage conditional-branch operand hazards. It freezes PC and IF/ID, injects bubbles into ID/EX, and flushes IF/ID after a taken branch.
- Sits beside the forwarding unit and drives the PC, IF/ID and ID/EX control.

Parameters:
- FLUSH_CYCLES, 1, number of consecutive cycles IFID_Flush stays asserted after a taken branch (1..3).
- ZERO_REG, 5'd31, hardwired-zero register index; it never creates a hazard.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- ID_Rn  in  5  first source register of the instruction in ID
- ID_Rm  in  5  second source register (Rt for CBZ/STUR) in ID
- ID_UsesRn  in  1  ID instruction reads Rn
- ID_UsesRm  in  1  ID instruction reads Rm/Rt
- ID_IsCondBr  in  1  ID holds CBZ/CBNZ, compared in ID using Rt (ID_Rm)
- BrTaken  in  1  branch resolved taken in ID this cycle
- Ex_Rd  in  5  destination register in EX
- Ex_RegWE  in  1  EX instruction writes the register file
- Ex_MemRead  in  1  EX instruction is a load
- Mem_Rd  in  5  destination register in MEM
- Mem_MemRead  in  1  MEM instruction is a load
- PC_WE  out  1  PC write enable
- IFID_WE  out  1  IF/ID register write enable
- IDEX_Bubble  out  1  zero ID/EX control bits next edge
- IFID_Flush  out  1  clear IF/ID to NOP next edge
- Stalling  out  1  a stall is in progress (debug/perf)

Behaviour:
- States: RUN, STALL, FLUSH. The state register and a 2-bit counter `cnt` update on the rising clk edge.
- Reset (synchronous, checked first):
  - State becomes RUN and cnt becomes 0.
  - While reset is high, outputs are forced: PC_WE=0, IFID_WE=0, IDEX_Bubble=1, IFID_Flush=1, Stalling=0.
- A register "matches" only if it equals the producer Rd and Rd != ZERO_REG.
- Hazard needs (N = stall cycles), evaluated combinationally in RUN:
  - Load-use: Ex_MemRead and Ex_Rd matches a used source (ID_Rn with ID_UsesRn, or ID_Rm with ID_UsesRm), and ID_IsCondBr=0 → N=1.
  - Branch on ALU result: ID_IsCondBr, Ex_RegWE, !Ex_MemRead, Ex_Rd matches ID_Rm → N=1.
  - Branch on load in EX: ID_IsCondBr, Ex_MemRead, Ex_Rd matches ID_Rm → N=2.
  - Branch on load in MEM: ID_IsCondBr, Mem_MemRead, Mem_Rd matches ID_Rm → N=1.
  - When several needs apply, N is the maximum.
- RUN with N>0 (Mealy, same cycle):
  - Outputs: PC_WE=0, IFID_WE=0, IDEX_Bubble=1, Stalling=1.
  - BrTaken is ignored.
  - If N=2, go to STALL with cnt=1; otherwise stay in RUN.
- STALL:
  - Same outputs as a RUN stall, independent of inputs.
  - cnt decrements each cycle; the FSM returns to RUN after the cycle in which cnt=1.
  - After returning to RUN the hazard is re-evaluated, so a still-present dependency re-stalls.
- RUN with N=0 and BrTaken:
  - Outputs: IFID_Flush=1, PC_WE=1, IFID_WE=1.
  - If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-1.
- FLUSH:
  - Outputs: IFID_Flush=1, PC_WE=1, no hazard evaluation, BrTaken ignored.
  - cnt decrements; the FSM returns to RUN after the cycle in which cnt=1.
- RUN idle outputs: PC_WE=1, IFID_WE=1, IDEX_Bubble=0, IFID_Flush=0, Stalling=0.
- Stall and flush are never asserted together.
- Reset asserted during STALL or FLUSH aborts the sequence immediately.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - Adds outputs StallCount[31:0] and FlushCount[31:0].
  - Each increments by 1 per cycle in which Stalling or IFID_Flush (respectively) is asserted outside reset.
  - Both saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - typedef enum logic [1:0] {RUN, STALL, FLUSH} haz_state_t.
  - localparam ZERO_REG_IDX = 5'd31.
  - typedef logic [4:0] reg_idx_t.
- One natural sub-module, hazard_detect (purely combinational), computes N from the register/control inputs.
- The FSM, counter and optional perf counters stay in the top-level hazard_stall_unit.

Test Plan:
- LDUR X2 in EX (Ex_MemRead=1, Ex_Rd=2), ADD in ID reading Rn=2 → exactly one cycle with PC_WE=0, IFID_WE=0, IDEX_Bubble=1, then PC_WE=1.
- Same as above but Ex_Rd=31 → no stall; PC_WE stays 1.
- CBZ X5 in ID, LDUR X5 in EX → two consecutive stall cycles (RUN→STALL→RUN), Stalling=1 for exactly 2 cycles.
- CBZ X5 in ID, ADD X5 in EX (Ex_RegWE=1) → one stall; next cycle with Mem_Rd=5 and Mem_MemRead=0 → no stall.
- BrTaken=1 with no hazard, FLUSH_CYCLES=2 → IFID_Flush=1 for 2 cycles, PC_WE=1 throughout; BrTaken together with a load-use hazard → stall only, IFID_Flush=0.
- reset pulsed in the 2nd cycle of the CBZ/load stall → next cycle is RUN idle, outputs PC_WE=1, Stalling=0; with HAZARD_PERF_CNT_EN defined, StallCount reads 0 after reset.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types for the hazard/stall controller: FSM states,
// register index type and the hardwired-zero register index.
package pipe_pkg;
  typedef enum logic [1:0] {RUN, STALL, FLUSH} haz_state_t;
  typedef logic [4:0] reg_idx_t;
  localparam reg_idx_t ZERO_REG_IDX = 5'd31;
endpackage

// File: rtl/hazard_detect.sv
// Combinational stall-need computation for the ID-stage instruction.
// need = number of stall cycles required (0, 1 or 2); the largest applicable need wins.
module hazard_detect
  import pipe_pkg::*;
#(
  parameter reg_idx_t ZERO_REG = ZERO_REG_IDX
) (
  input  reg_idx_t   ID_Rn,
  input  reg_idx_t   ID_Rm,
  input  logic       ID_UsesRn,
  input  logic       ID_UsesRm,
  input  logic       ID_IsCondBr,
  input  reg_idx_t   Ex_Rd,
  input  logic       Ex_RegWE,
  input  logic       Ex_MemRead,
  input  reg_idx_t   Mem_Rd,
  input  logic       Mem_MemRead,
  output logic [1:0] need
);

  logic ex_rn_hit;
  logic ex_rm_hit;
  logic mem_rm_hit;

  assign ex_rn_hit  = (ID_Rn == Ex_Rd)  && (Ex_Rd  != ZERO_REG);
  assign ex_rm_hit  = (ID_Rm == Ex_Rd)  && (Ex_Rd  != ZERO_REG);
  assign mem_rm_hit = (ID_Rm == Mem_Rd) && (Mem_Rd != ZERO_REG);

  // CBZ/CBNZ compare in ID, so only Rt (ID_Rm) matters for branches.
  always_comb begin
    need = 2'd0;
    if (ID_IsCondBr) begin
      if (Ex_MemRead && ex_rm_hit) begin
        need = 2'd2;
      end else if ((Ex_RegWE && ex_rm_hit) || (Mem_MemRead && mem_rm_hit)) begin
        need = 2'd1;
      end
    end else if (Ex_MemRead && ((ID_UsesRn && ex_rn_hit) || (ID_UsesRm && ex_rm_hit))) begin
      need = 2'd1;
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use and ID-branch
// operand stalls, post-branch IF/ID flush. Optional perf counters: HAZARD_PERF_CNT_EN.
//
// state | meaning
// RUN   | normal issue; hazards evaluated, stalls/flushes start here
// STALL | extra stall cycle for CBZ/CBNZ on a load still in EX
// FLUSH | extra IF/ID flush cycles after a taken branch
module hazard_stall_unit
  import pipe_pkg::*;
#(
  parameter int       FLUSH_CYCLES = 1,
  parameter reg_idx_t ZERO_REG     = ZERO_REG_IDX
) (
  input  logic     clk,
  input  logic     reset,
  input  reg_idx_t ID_Rn,
  input  reg_idx_t ID_Rm,
  input  logic     ID_UsesRn,
  input  logic     ID_UsesRm,
  input  logic     ID_IsCondBr,
  input  logic     BrTaken,
  input  reg_idx_t Ex_Rd,
  input  logic     Ex_RegWE,
  input  logic     Ex_MemRead,
  input  reg_idx_t Mem_Rd,
  input  logic     Mem_MemRead,
  output logic     PC_WE,
  output logic     IFID_WE,
  output logic     IDEX_Bubble,
  output logic     IFID_Flush,
  output logic     Stalling
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount
`endif
);

  localparam logic [1:0] FLUSH_CNT = 2'(FLUSH_CYCLES - 1);

  haz_state_t state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic [1:0] need;

  hazard_detect #(.ZERO_REG(ZERO_REG)) u_detect (
    .ID_Rn       (ID_Rn),
    .ID_Rm       (ID_Rm),
    .ID_UsesRn   (ID_UsesRn),
    .ID_UsesRm   (ID_UsesRm),
    .ID_IsCondBr (ID_IsCondBr),
    .Ex_Rd       (Ex_Rd),
    .Ex_RegWE    (Ex_RegWE),
    .Ex_MemRead  (Ex_MemRead),
    .Mem_Rd      (Mem_Rd),
    .Mem_MemRead (Mem_MemRead),
    .need        (need)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    PC_WE       = 1'b1;
    IFID_WE     = 1'b1;
    IDEX_Bubble = 1'b0;
    IFID_Flush  = 1'b0;
    Stalling    = 1'b0;
    case (state)
      RUN: begin
        if (need != 2'd0) begin
          PC_WE       = 1'b0;
          IFID_WE     = 1'b0;
          IDEX_Bubble = 1'b1;
          Stalling    = 1'b1;
          if (need == 2'd2) begin
            state_nxt = STALL;
            cnt_nxt   = 2'd1;
          end
        end else if (BrTaken) begin
          IFID_Flush = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_nxt = FLUSH;
            cnt_nxt   = FLUSH_CNT;
          end
        end
      end
      STALL: begin
        PC_WE       = 1'b0;
        IFID_WE     = 1'b0;
        IDEX_Bubble = 1'b1;
        Stalling    = 1'b1;
        cnt_nxt     = cnt - 2'd1;
        if (cnt <= 2'd1) state_nxt = RUN;
      end
      FLUSH: begin
        IFID_Flush = 1'b1;
        cnt_nxt    = cnt - 2'd1;
        if (cnt <= 2'd1) state_nxt = RUN;
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = 2'd0;
      end
    endcase
    // Reset overrides everything: hold PC, bubble ID/EX and clear IF/ID.
    if (reset) begin
      PC_WE       = 1'b0;
      IFID_WE     = 1'b0;
      IDEX_Bubble = 1'b1;
      IFID_Flush  = 1'b1;
      Stalling    = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      StallCount <= 32'd0;
      FlushCount <= 32'd0;
    end else begin
      if (Stalling && (StallCount != 32'hFFFF_FFFF)) StallCount <= StallCount + 32'd1;
      if (IFID_Flush && (FlushCount != 32'hFFFF_FFFF)) FlushCount <= FlushCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed, table-driven self-checking bench for hazard_stall_unit (FLUSH_CYCLES=2).
module tb_hazard_stall_unit;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic reset;
  reg_idx_t ID_Rn, ID_Rm, Ex_Rd, Mem_Rd;
  logic ID_UsesRn, ID_UsesRm, ID_IsCondBr, BrTaken;
  logic Ex_RegWE, Ex_MemRead, Mem_MemRead;
  logic PC_WE, IFID_WE, IDEX_Bubble, IFID_Flush, Stalling;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] StallCount, FlushCount;
`endif

  int total = 0;
  int passed = 0;
  int stall_cycles;

  always #5 clk = ~clk;

  hazard_stall_unit #(.FLUSH_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_UsesRn(ID_UsesRn), .ID_UsesRm(ID_UsesRm),
    .ID_IsCondBr(ID_IsCondBr), .BrTaken(BrTaken),
    .Ex_Rd(Ex_Rd), .Ex_RegWE(Ex_RegWE), .Ex_MemRead(Ex_MemRead),
    .Mem_Rd(Mem_Rd), .Mem_MemRead(Mem_MemRead),
    .PC_WE(PC_WE), .IFID_WE(IFID_WE), .IDEX_Bubble(IDEX_Bubble),
    .IFID_Flush(IFID_Flush), .Stalling(Stalling)
`ifdef HAZARD_PERF_CNT_EN
    , .StallCount(StallCount), .FlushCount(FlushCount)
`endif
  );

  // {PC_WE, IFID_WE, IDEX_Bubble, IFID_Flush, Stalling}
  localparam logic [4:0] O_IDLE  = 5'b11000;
  localparam logic [4:0] O_STALL = 5'b00101;
  localparam logic [4:0] O_BR    = 5'b11010;
  localparam logic [4:0] O_RST   = 5'b00110;

  function automatic logic [4:0] outs();
    return {PC_WE, IFID_WE, IDEX_Bubble, IFID_Flush, Stalling};
  endfunction

  typedef struct {
    string      name;
    logic [4:0] rn, rm;
    logic       urn, urm, cbr, brt;
    logic [4:0] exrd;
    logic       exwe, exmr;
    logic [4:0] memrd;
    logic       memmr;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    ID_Rn = 5'd0; ID_Rm = 5'd0; ID_UsesRn = 1'b0; ID_UsesRm = 1'b0;
    ID_IsCondBr = 1'b0; BrTaken = 1'b0;
    Ex_Rd = 5'd0; Ex_RegWE = 1'b0; Ex_MemRead = 1'b0;
    Mem_Rd = 5'd0; Mem_MemRead = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    ID_Rn = v.rn; ID_Rm = v.rm; ID_UsesRn = v.urn; ID_UsesRm = v.urm;
    ID_IsCondBr = v.cbr; BrTaken = v.brt;
    Ex_Rd = v.exrd; Ex_RegWE = v.exwe; Ex_MemRead = v.exmr;
    Mem_Rd = v.memrd; Mem_MemRead = v.memmr;
  endtask

  // LDUR X2 in EX, ADD in ID reading X2 through Rn
  task automatic load_use_rn2();
    set_idle();
    ID_Rn = 5'd2; ID_UsesRn = 1'b1; Ex_Rd = 5'd2; Ex_RegWE = 1'b1; Ex_MemRead = 1'b1;
  endtask

  // CBZ X5 in ID, LDUR X5 in EX
  task automatic cbz_on_load();
    set_idle();
    ID_Rm = 5'd5; ID_UsesRm = 1'b1; ID_IsCondBr = 1'b1;
    Ex_Rd = 5'd5; Ex_RegWE = 1'b1; Ex_MemRead = 1'b1;
  endtask

  initial begin
    //          name           rn     rm    urn urm cbr brt exrd  we  mr memrd mmr  exp
    vecs[0]  = '{"idle",        5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, O_IDLE};
    vecs[1]  = '{"lu_rn",       5'd2, 5'd9, 1, 1, 0, 0, 5'd2, 1, 1, 5'd0, 0, O_STALL};
    vecs[2]  = '{"lu_rm",       5'd1, 5'd7, 1, 1, 0, 0, 5'd7, 1, 1, 5'd0, 0, O_STALL};
    vecs[3]  = '{"lu_zero",     5'd31,5'd31,1, 1, 0, 0, 5'd31,1, 1, 5'd0, 0, O_IDLE};
    vecs[4]  = '{"lu_unused",   5'd2, 5'd9, 0, 1, 0, 0, 5'd2, 1, 1, 5'd0, 0, O_IDLE};
    vecs[5]  = '{"cbr_rn_only", 5'd3, 5'd4, 1, 1, 1, 0, 5'd3, 1, 1, 5'd0, 0, O_IDLE};
    vecs[6]  = '{"br_alu",      5'd0, 5'd5, 0, 1, 1, 0, 5'd5, 1, 0, 5'd0, 0, O_STALL};
    vecs[7]  = '{"br_alu_nowe", 5'd0, 5'd5, 0, 1, 1, 0, 5'd5, 0, 0, 5'd0, 0, O_IDLE};
    vecs[8]  = '{"br_memload",  5'd0, 5'd5, 0, 1, 1, 0, 5'd9, 1, 0, 5'd5, 1, O_STALL};
    vecs[9]  = '{"br_mem_zero", 5'd0, 5'd31,0, 1, 1, 0, 5'd9, 0, 0, 5'd31,1, O_IDLE};
    vecs[10] = '{"br_with_lu",  5'd2, 5'd9, 1, 1, 0, 1, 5'd2, 1, 1, 5'd0, 0, O_STALL};
    vecs[11] = '{"lu_nomatch",  5'd2, 5'd3, 1, 1, 0, 0, 5'd4, 1, 1, 5'd0, 0, O_IDLE};
    vecs[12] = '{"alu_fwd",     5'd2, 5'd3, 1, 1, 0, 0, 5'd2, 1, 0, 5'd2, 0, O_IDLE};

    reset = 1'b1;
    set_idle();
    #1;
    check("reset_outs", 32'(outs()), 32'(O_RST));
    next_cycle();
    reset = 1'b0;
    #1;
    check("post_reset_idle", 32'(outs()), 32'(O_IDLE));
    next_cycle();

    // All table vectors leave the FSM in RUN.
    for (int i = 0; i < 13; i++) begin
      apply(vecs[i]);
      #1;
      check(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
      next_cycle();
    end

    // Load-use: exactly one stall cycle, then the bubble has moved on.
    load_use_rn2();
    #1;
    check("lu_seq_stall", 32'(outs()), 32'(O_STALL));
    next_cycle();
    set_idle();
    ID_Rn = 5'd2; ID_UsesRn = 1'b1;
    #1;
    check("lu_seq_release", 32'(outs()), 32'(O_IDLE));
    next_cycle();

    // CBZ on load in EX: two stall cycles, second independent of inputs.
    stall_cycles = 0;
    cbz_on_load();
    #1;
    check("cbz_ld_c1", 32'(outs()), 32'(O_STALL));
    stall_cycles += int'(Stalling);
    next_cycle();
    set_idle();
    BrTaken = 1'b1;
    #1;
    check("cbz_ld_c2", 32'(outs()), 32'(O_STALL));
    stall_cycles += int'(Stalling);
    next_cycle();
    BrTaken = 1'b0;
    #1;
    check("cbz_ld_c3", 32'(outs()), 32'(O_IDLE));
    stall_cycles += int'(Stalling);
    check("cbz_ld_stall_cnt", 32'(stall_cycles), 32'd2);
    next_cycle();

    // Dependency still present after STALL re-stalls.
    cbz_on_load();
    next_cycle();
    next_cycle();
    #1;
    check("cbz_ld_restall", 32'(outs()), 32'(O_STALL));
    next_cycle();
    set_idle();
    #1;
    check("cbz_ld_restall2", 32'(outs()), 32'(O_STALL));
    next_cycle();
    #1;
    check("cbz_ld_restall_end", 32'(outs()), 32'(O_IDLE));
    next_cycle();

    // CBZ on ALU result: one stall, then producer in MEM (not a load) is fine.
    set_idle();
    ID_Rm = 5'd5; ID_IsCondBr = 1'b1; Ex_Rd = 5'd5; Ex_RegWE = 1'b1;
    #1;
    check("cbz_alu_stall", 32'(outs()), 32'(O_STALL));
    next_cycle();
    Ex_Rd = 5'd0; Ex_RegWE = 1'b0; Mem_Rd = 5'd5; Mem_MemRead = 1'b0;
    #1;
    check("cbz_alu_mem_ok", 32'(outs()), 32'(O_IDLE));
    next_cycle();

    // Taken branch: two flush cycles; hazard ignored while in FLUSH.
    set_idle();
    BrTaken = 1'b1;
    #1;
    check("br_flush_c1", 32'(outs()), 32'(O_BR));
    next_cycle();
    load_use_rn2();
    #1;
    check("br_flush_c2_pcwe", 32'(PC_WE), 32'd1);
    check("br_flush_c2_flush", 32'(IFID_Flush), 32'd1);
    check("br_flush_c2_nostall", 32'({IDEX_Bubble, Stalling}), 32'd0);
    next_cycle();
    #1;
    check("br_flush_after", 32'(outs()), 32'(O_STALL));
    next_cycle();
    set_idle();
    #1;
    check("br_flush_done", 32'(outs()), 32'(O_IDLE));
    next_cycle();

    // Reset in the second cycle of the CBZ/load stall aborts it.
    cbz_on_load();
    #1;
    check("rst_abort_c1", 32'(outs()), 32'(O_STALL));
    next_cycle();
    set_idle();
    reset = 1'b1;
    #1;
    check("rst_abort_forced", 32'(outs()), 32'(O_RST));
    next_cycle();
    reset = 1'b0;
    #1;
    check("rst_abort_idle", 32'(outs()), 32'(O_IDLE));
`ifdef HAZARD_PERF_CNT_EN
    check("rst_stallcount", StallCount, 32'd0);
`endif
    next_cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
